// File: rtl/leaf_pkg.sv
// Shared field widths, bit positions, packet layout and FSM encoding for the
// BFT leaf packetizer.
package leaf_pkg;

  localparam int unsigned PKT_BITS  = 49;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned LEAF_BITS = 5;
  localparam int unsigned PORT_BITS = 4;
  localparam int unsigned SEQ_BITS  = 7;

  localparam int unsigned VLD_POS  = 48;
  localparam int unsigned LEAF_LSB = 43;
  localparam int unsigned PORT_LSB = 39;
  localparam int unsigned SEQ_LSB  = 32;

  typedef struct packed {
    logic                 vld;
    logic [LEAF_BITS-1:0] leaf;
    logic [PORT_BITS-1:0] port;
    logic [SEQ_BITS-1:0]  seq;
    logic [DATA_BITS-1:0] payload;
  } pkt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/leaf_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after ptr
// (0-based, ptr 0 = user port 1) and the pointer following the winner.
module leaf_rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] next_ptr
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;
  logic [IDX_W:0] pos;
  logic           found;

  // Rotate so bit 0 is the pointer position, priority-pick, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    gnt_rot = '0;
    pos     = {1'b0, ptr};
    found   = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      if (!found && req_rot[off]) begin
        found        = 1'b1;
        gnt_rot[off] = 1'b1;
        pos          = {1'b0, ptr} + (IDX_W+1)'(off);
      end
    end
    if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
    gnt_dbl  = {gnt_rot, gnt_rot} << ptr;
    grant    = en ? gnt_dbl[2*N-1:N] : '0;
    next_ptr = (pos == (IDX_W+1)'(N-1)) ? '0 : IDX_W'(pos + 1'b1);
  end

endmodule

// File: rtl/leaf_packetizer.sv
// Arbitrates user output streams into stamped BFT packets with one output
// register. Optional `LEAF_PKT_CNT_EN adds pkt_cnt (packets taken by the BFT).
module leaf_packetizer
  import leaf_pkg::*;
#(
  parameter int unsigned PACKET_BITS   = PKT_BITS,
  parameter int unsigned PAYLOAD_BITS  = DATA_BITS,
  parameter int unsigned NUM_LEAF_BITS = LEAF_BITS,
  parameter int unsigned NUM_PORT_BITS = PORT_BITS,
  parameter int unsigned NUM_ADDR_BITS = SEQ_BITS,
  parameter int unsigned NUM_OUT_PORTS = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]          vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]          ack_interface2user,
  input  logic                              cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]          cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]          cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]          cfg_dport,
  input  logic                              bft_ready,
  input  logic                              resend,
`ifdef LEAF_PKT_CNT_EN
  output logic [31:0]                       pkt_cnt,
`endif
  output logic [PACKET_BITS-1:0]            dout_leaf_interface2bft
);

  state_e                   state_q, state_d;
  pkt_t                     pkt_q, pkt_d;
  logic [NUM_PORT_BITS-1:0] ptr_q, ptr_d, ptr_nxt;
  logic [NUM_ADDR_BITS-1:0] seq_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_d   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_q  [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_d  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_d [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     accept_en;
  logic                     drain;

  assign accept_en = ((state_q == ST_IDLE) || bft_ready) && !resend;
  assign drain     = (state_q == ST_HOLD) && bft_ready && !resend;

  leaf_rr_arbiter #(
    .N     (NUM_OUT_PORTS),
    .IDX_W (NUM_PORT_BITS)
  ) u_arb (
    .req      (vld_user2interface),
    .en       (accept_en),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (ptr_nxt)
  );

  assign ack_interface2user      = grant;
  assign dout_leaf_interface2bft = resend ? '0 : pkt_q;

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    ptr_d   = ptr_q;
    seq_d   = seq_q;
    leaf_d  = leaf_q;
    dport_d = dport_q;
    if (drain) begin
      state_d = ST_IDLE;
      pkt_d   = '0;
    end
    // Packet fields read the pre-write table, so a same-cycle cfg write to
    // the granted port applies only from the next packet.
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        pkt_d.vld     = 1'b1;
        pkt_d.leaf    = leaf_q[i];
        pkt_d.port    = dport_q[i];
        pkt_d.seq     = seq_q[i];
        pkt_d.payload = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        state_d       = ST_HOLD;
        ptr_d         = ptr_nxt;
        seq_d[i]      = seq_q[i] + 1'b1;
      end
      if (cfg_wr && (cfg_port == NUM_PORT_BITS'(i + 1))) begin
        leaf_d[i]  = cfg_leaf;
        dport_d[i] = cfg_dport;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pkt_q   <= '0;
      ptr_q   <= '0;
      seq_q   <= '{default: '0};
      leaf_q  <= '{default: '0};
      dport_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      ptr_q   <= ptr_d;
      seq_q   <= seq_d;
      leaf_q  <= leaf_d;
      dport_q <= dport_d;
    end
  end

`ifdef LEAF_PKT_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule
